// File: rtl/phrase_char_decoder.sv
// Reassembles one 16-bit phrase word {note, volume, instrument} from a 6-character ASCII record.
// Optional build macro: PHRASE_DECODER_LOWERCASE_EN also accepts lowercase note letters.
module phrase_char_decoder #(
    parameter int MAX_OCTAVE = 9,
    parameter int MAX_VOLUME = 63
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        char_valid,
    input  logic [6:0]  char_code,
    input  logic        char_sof,
    output logic        char_ready,
    output logic        phrase_valid,
    input  logic        phrase_ready,
    output logic [15:0] phrase_out,
    output logic        phrase_err
);

    typedef enum logic [2:0] {
        S_LETTER,
        S_SHARP,
        S_OCT,
        S_VOLT,
        S_VOLO,
        S_INST,
        S_OUT
    } state_t;

    state_t      state, state_next;
    logic [3:0]  idx, idx_next;
    logic [3:0]  oct, oct_next;
    logic [3:0]  tens, tens_next;
    logic [5:0]  vol, vol_next;
    logic        err, err_next;
    logic [15:0] out_next;
    logic        out_err_next;

    logic        accept;
    logic        resync;
    logic [4:0]  letter;
    logic [6:0]  vol_sum;
    logic [7:0]  note_val;
    logic        inst_ok;
    logic        final_err;

    // Returns {legal, semitone index within the octave}.
    function automatic logic [4:0] letter_lookup(input logic [6:0] code);
        logic [6:0] c;
        c = code;
`ifdef PHRASE_DECODER_LOWERCASE_EN
        if (code >= 7'h61 && code <= 7'h67) begin
            c = code - 7'h20;
        end
`endif
        case (c)
            7'h43:   return {1'b1, 4'd0};
            7'h44:   return {1'b1, 4'd2};
            7'h45:   return {1'b1, 4'd4};
            7'h46:   return {1'b1, 4'd5};
            7'h47:   return {1'b1, 4'd7};
            7'h41:   return {1'b1, 4'd9};
            7'h42:   return {1'b1, 4'd11};
            default: return {1'b0, 4'd0};
        endcase
    endfunction

    function automatic logic digit_ok(input logic [6:0] code, input int max_digit);
        int v;
        v = int'(code) - 48;
        return (v >= 0) && (v <= max_digit);
    endfunction

    assign char_ready   = (state != S_OUT);
    assign phrase_valid = (state == S_OUT);

    assign accept   = char_valid && char_ready;
    assign resync   = accept && char_sof && (state != S_LETTER);
    assign letter   = letter_lookup(char_code);
    assign vol_sum  = {3'b000, tens} * 7'd10 + {3'b000, char_code[3:0]};
    assign note_val = {4'b0000, oct} * 8'd12 + {4'b0000, idx};
    assign inst_ok  = digit_ok(char_code, 3);
    assign final_err = err || !inst_ok;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_LETTER;
            idx        <= '0;
            oct        <= '0;
            tens       <= '0;
            vol        <= '0;
            err        <= 1'b0;
            phrase_out <= '0;
            phrase_err <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            oct        <= oct_next;
            tens       <= tens_next;
            vol        <= vol_next;
            err        <= err_next;
            phrase_out <= out_next;
            phrase_err <= out_err_next;
        end
    end

    always_comb begin
        state_next   = state;
        idx_next     = idx;
        oct_next     = oct;
        tens_next    = tens;
        vol_next     = vol;
        err_next     = err;
        out_next     = phrase_out;
        out_err_next = phrase_err;

        if (state == S_OUT) begin
            if (phrase_ready) begin
                state_next = S_LETTER;
            end
        end else if (accept) begin
            // A start-of-record char restarts decoding from the letter, dropping the partial record.
            if (resync || state == S_LETTER) begin
                idx_next   = letter[3:0];
                err_next   = !letter[4];
                oct_next   = '0;
                tens_next  = '0;
                vol_next   = '0;
                state_next = S_SHARP;
            end else begin
                case (state)
                    S_SHARP: begin
                        if (char_code == 7'h23) begin
                            if (idx == 4'd4 || idx == 4'd11) begin
                                err_next = 1'b1;
                            end
                            idx_next = idx + 4'd1;
                        end else if (char_code != 7'h00 && char_code != 7'h20) begin
                            err_next = 1'b1;
                        end
                        state_next = S_OCT;
                    end
                    S_OCT: begin
                        if (digit_ok(char_code, MAX_OCTAVE)) begin
                            oct_next = char_code[3:0];
                        end else begin
                            err_next = 1'b1;
                        end
                        state_next = S_VOLT;
                    end
                    S_VOLT: begin
                        if (digit_ok(char_code, 9)) begin
                            tens_next = char_code[3:0];
                        end else begin
                            err_next = 1'b1;
                        end
                        state_next = S_VOLO;
                    end
                    S_VOLO: begin
                        if (!digit_ok(char_code, 9) || int'(vol_sum) > MAX_VOLUME) begin
                            err_next = 1'b1;
                        end else begin
                            vol_next = vol_sum[5:0];
                        end
                        state_next = S_INST;
                    end
                    S_INST: begin
                        // Malformed records are reported with a zeroed word.
                        err_next     = final_err;
                        out_err_next = final_err;
                        out_next     = final_err ? 16'h0000 : {note_val, vol, char_code[1:0]};
                        state_next   = S_OUT;
                    end
                    default: begin
                        state_next = S_LETTER;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_phrase_char_decoder.sv
// Directed and randomized checks of phrase_char_decoder against an arithmetic reference model.
module tb_phrase_char_decoder;

    localparam int MAX_OCTAVE = 9;
    localparam int MAX_VOLUME = 63;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        char_valid;
    logic [6:0]  char_code;
    logic        char_sof;
    logic        char_ready;
    logic        phrase_valid;
    logic        phrase_ready;
    logic [15:0] phrase_out;
    logic        phrase_err;

    int vectors = 0;
    int miscompares = 0;
    logic [6:0] rec [6];

    always #5 clk = ~clk;

    phrase_char_decoder #(.MAX_OCTAVE(MAX_OCTAVE), .MAX_VOLUME(MAX_VOLUME)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .char_valid(char_valid),
        .char_code(char_code),
        .char_sof(char_sof),
        .char_ready(char_ready),
        .phrase_valid(phrase_valid),
        .phrase_ready(phrase_ready),
        .phrase_out(phrase_out),
        .phrase_err(phrase_err)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: decode the record in rec[] straight from the character rules.
    function automatic logic [16:0] model();
        string names = "C D EF G A B";
        int    idx = -1;
        int    letter, oct, t, o, vol, inst, note;
        bit    err = 0;
        letter = int'(rec[0]);
`ifdef PHRASE_DECODER_LOWERCASE_EN
        if (letter >= 97 && letter <= 103) letter -= 32;
`endif
        for (int i = 0; i < 12; i++)
            if (names[i] != " " && int'(names[i]) == letter) idx = i;
        if (idx < 0) err = 1;
        if (rec[1] == 7'h23) begin
            if (idx == 4 || idx == 11) err = 1;
            idx++;
        end else if (rec[1] != 7'h00 && rec[1] != 7'h20) begin
            err = 1;
        end
        oct  = int'(rec[2]) - 48;
        t    = int'(rec[3]) - 48;
        o    = int'(rec[4]) - 48;
        inst = int'(rec[5]) - 48;
        if (oct < 0 || oct > MAX_OCTAVE) err = 1;
        if (t < 0 || t > 9 || o < 0 || o > 9) err = 1;
        vol = t * 10 + o;
        if (vol > MAX_VOLUME) err = 1;
        if (inst < 0 || inst > 3) err = 1;
        if (err) return {1'b1, 16'h0000};
        note = oct * 12 + idx;
        return {1'b0, 8'(note), 6'(vol), 2'(inst)};
    endfunction

    task automatic send_char(input logic [6:0] c, input logic sof, input int gap);
        int n = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        char_valid = 1'b1;
        char_code  = c;
        char_sof   = sof;
        while (!char_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("char_ready_timeout", 32'(char_ready), 32'd1);
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        char_sof   = 1'b0;
    endtask

    task automatic send_record(input int max_gap);
        for (int i = 0; i < 6; i++) begin
            send_char(rec[i], (i == 0) ? 1'($urandom_range(0, 1)) : 1'b0, $urandom_range(0, max_gap));
        end
    endtask

    task automatic run_record(input logic [16:0] exp, input int stall, input int max_gap, input string tag);
        send_record(max_gap);
        @(negedge clk);
        check({tag, "_latency"}, 32'(phrase_valid), 32'd1);
        if (phrase_valid) begin
            for (int s = 0; s < stall; s++) begin
                check({tag, "_stall_valid"}, 32'(phrase_valid), 32'd1);
                check({tag, "_stall_out"}, 32'(phrase_out), 32'(exp[15:0]));
                check({tag, "_stall_ready"}, 32'(char_ready), 32'd0);
                @(negedge clk);
            end
            check({tag, "_out"}, 32'(phrase_out), 32'(exp[15:0]));
            check({tag, "_err"}, 32'(phrase_err), 32'(exp[16]));
            phrase_ready = 1'b1;
            @(posedge clk);
            #1;
            phrase_ready = 1'b0;
            check({tag, "_ready_after"}, 32'(char_ready), 32'd1);
        end
    endtask

    task automatic set_rec(input logic [6:0] a, b, c, d, e, f);
        rec[0] = a; rec[1] = b; rec[2] = c; rec[3] = d; rec[4] = e; rec[5] = f;
    endtask

    initial begin
        logic [16:0] exp;
        logic [6:0]  letters [12];
        reset_n      = 1'b0;
        char_valid   = 1'b0;
        char_code    = '0;
        char_sof     = 1'b0;
        phrase_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(phrase_valid), 32'd0);
        check("rst_out", 32'(phrase_out), 32'd0);
        check("rst_err", 32'(phrase_err), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(char_ready), 32'd1);

        set_rec(7'h43, 7'h23, 7'h34, 7'h36, 7'h33, 7'h32);
        run_record({1'b0, 16'h31FE}, 0, 0, "c_sharp");
        set_rec(7'h41, 7'h00, 7'h30, 7'h30, 7'h30, 7'h30);
        run_record({1'b0, 16'h0900}, 0, 0, "a0");
        set_rec(7'h42, 7'h00, 7'h39, 7'h31, 7'h30, 7'h33);
        run_record({1'b0, 16'h772B}, 0, 1, "b9");

        set_rec(7'h45, 7'h23, 7'h33, 7'h31, 7'h30, 7'h30);
        run_record({1'b1, 16'h0000}, 0, 0, "e_sharp");
        set_rec(7'h43, 7'h00, 7'h33, 7'h36, 7'h34, 7'h30);
        run_record({1'b1, 16'h0000}, 0, 0, "vol64");
        set_rec(7'h58, 7'h00, 7'h33, 7'h31, 7'h30, 7'h30);
        run_record({1'b1, 16'h0000}, 0, 0, "bad_letter");
        set_rec(7'h43, 7'h20, 7'h33, 7'h31, 7'h30, 7'h34);
        run_record({1'b1, 16'h0000}, 0, 0, "inst4");

        set_rec(7'h43, 7'h23, 7'h34, 7'h36, 7'h33, 7'h32);
        run_record({1'b0, 16'h31FE}, 5, 0, "backpressure");

        send_char(7'h43, 1'b0, 0);
        send_char(7'h23, 1'b0, 0);
        send_char(7'h34, 1'b0, 0);
        send_char(7'h44, 1'b1, 0);
        @(negedge clk);
        check("resync_no_phrase", 32'(phrase_valid), 32'd0);
        set_rec(7'h00, 7'h32, 7'h30, 7'h35, 7'h31, 7'h00);
        for (int i = 0; i < 5; i++) send_char(rec[i], 1'b0, 0);
        @(negedge clk);
        check("resync_latency", 32'(phrase_valid), 32'd1);
        check("resync_out", 32'(phrase_out), 32'h1A15);
        check("resync_err", 32'(phrase_err), 32'd0);
        phrase_ready = 1'b1;
        @(posedge clk);
        #1;
        phrase_ready = 1'b0;

        send_char(7'h47, 1'b0, 0);
        send_char(7'h00, 1'b0, 0);
        send_char(7'h31, 1'b0, 0);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("midrst_valid", 32'(phrase_valid), 32'd0);
        check("midrst_out", 32'(phrase_out), 32'd0);
        check("midrst_err", 32'(phrase_err), 32'd0);
        set_rec(7'h47, 7'h00, 7'h31, 7'h31, 7'h32, 7'h30);
        run_record({1'b0, 16'h1330}, 0, 0, "after_rst");

        set_rec(7'h45, 7'h23, 7'h33, 7'h31, 7'h30, 7'h30);
        send_record(0);
        @(negedge clk);
        check("pend_valid", 32'(phrase_valid), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("pendrst_valid", 32'(phrase_valid), 32'd0);
        check("pendrst_err", 32'(phrase_err), 32'd0);

        letters = '{7'h43, 7'h44, 7'h45, 7'h46, 7'h47, 7'h41, 7'h42, 7'h63, 7'h61, 7'h58, 7'h48, 7'h00};
        for (int r = 0; r < 150; r++) begin
            int p;
            rec[0] = ($urandom_range(0, 9) < 8) ? letters[$urandom_range(0, 6)] : letters[$urandom_range(7, 11)];
            p = $urandom_range(0, 9);
            rec[1] = (p < 4) ? 7'h00 : (p < 6) ? 7'h20 : (p < 9) ? 7'h23 : 7'($urandom);
            for (int i = 2; i < 6; i++) begin
                if ($urandom_range(0, 15) == 0) rec[i] = 7'($urandom);
                else rec[i] = 7'h30 + 7'($urandom_range(0, (i == 5) ? 4 : 9));
            end
            exp = model();
            run_record(exp, $urandom_range(0, 3), 2, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/phrase_char_decoder.md
Name: phrase_char_decoder

Overview:
- Reverse of the phrase-to-character path: takes a stream of 7-bit ASCII character codes and reassembles one 16-bit phrase word, {note[15:8], volume[7:2], instrument[1:0]}.
- Character sources are user text entry or VRAM CODE fields read back, one character per handshake.
- Sits between the character source and the per-channel phrase registers in the HDMI text controller AXI block.
- Validates each record and flags malformed ones instead of writing garbage.

Parameters:
- MAX_OCTAVE, 9: highest legal octave digit; note = octave*12 + idx must fit in 8 bits.
- MAX_VOLUME, 63: highest legal decimal volume; must be ≤ 63 (6-bit field).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- char_valid  input  1  char_code is presented.
- char_code  input  7  ASCII code (the CODE field of a VRAM cell).
- char_sof  input  1  qualifies the current char as the first char of a record (resync).
- char_ready  output  1  decoder accepts a char this cycle.
- phrase_valid  output  1  phrase_out/phrase_err are valid.
- phrase_ready  input  1  consumer accepts the phrase.
- phrase_out  output  16  {note, volume, instrument}.
- phrase_err  output  1  record was malformed; phrase_out is forced to 0.

Behaviour:
- Reset: state=S_LETTER; phrase_valid=0, phrase_out=0, phrase_err=0; internal accumulators and error flag cleared. char_ready becomes 1 in the first cycle after reset is released.
- Transfer rule: a char is accepted only when char_valid && char_ready. A phrase is taken only when phrase_valid && phrase_ready.
- Record format, 6 characters in fixed order: letter, sharp-or-null, octave digit, volume tens, volume ones, instrument digit.
- FSM advances one state per accepted char:
  - S_LETTER → S_SHARP → S_OCT → S_VOLT → S_VOLO → S_INST → S_OUT.
  - S_OUT → S_LETTER on phrase handshake.
- char_ready = (state != S_OUT). No char is accepted while a phrase is pending, and phrase_valid stays high until taken.
- S_LETTER mapping: 'C'(0x43)=0, 'D'=2, 'E'=4, 'F'=5, 'G'=7, 'A'(0x41)=9, 'B'=11. Any other code sets err.
- S_SHARP:
  - 0x23 '#' adds 1 to idx. 0x00 or 0x20 adds 0.
  - '#' after E or B sets err.
  - Any other code sets err.
- S_OCT: '0'..('0'+MAX_OCTAVE) is legal; otherwise err.
- S_VOLT, S_VOLO: each must be '0'..'9', else err. vol = tens*10 + ones, computed at 7-bit width; vol > MAX_VOLUME sets err.
- S_INST: '0'..'3' is legal; otherwise err.
- Note arithmetic: note = oct*12 + idx, computed at 8-bit width with no truncation for legal inputs.
- Error handling:
  - err is sticky for the current record.
  - Decoding keeps consuming the remaining chars so framing is preserved.
  - On entry to S_OUT with err=1: phrase_out=0, phrase_err=1.
- Latency: phrase_valid asserts the cycle after the 6th char is accepted. phrase_out and phrase_err are registered and held stable while phrase_valid=1.
- Resync: an accepted char with char_sof=1 in any state other than S_LETTER aborts the partial record. Accumulators and err are cleared, and that char is decoded as a letter (next state S_SHARP). No phrase is emitted for the aborted record. char_sof in S_LETTER has no extra effect.
- Back-to-back records: after the phrase handshake in cycle N, char_ready=1 in cycle N+1. Maximum throughput is one phrase per 7 cycles.
- Reset mid-record or while phrase_valid=1: the partial or pending phrase is discarded and all reset values apply.

Optional Feature:
- PHRASE_DECODER_LOWERCASE_EN defined: in S_LETTER, 'a'..'g' (0x61..0x67) are accepted and decoded exactly as their uppercase equivalents.
- Undefined: lowercase codes set err like any other illegal letter.

Test Plan:
- chars 'C','#','4','6','3','2' (0x43,0x23,0x34,0x36,0x33,0x32), phrase_ready=1 → phrase_out=0x31FE (note 49, vol 63, inst 2), phrase_err=0, phrase_valid asserts 1 cycle after 6th char.
- chars 'A',0x00,'0','0','0','0' → phrase_out=0x0900, phrase_err=0; then 'B',0x00,'9','1','0','3' → note 119, vol 10 → phrase_out=0x772B.
- error records, each → phrase_err=1, phrase_out=0x0000, exactly one phrase per 6 chars:
  - 'E','#','3','1','0','0'
  - 'C',0x00,'3','6','4','0' (vol 64)
  - 'X',...
  - inst '4'
- backpressure: complete record with phrase_ready=0 for 5 cycles → phrase_valid and phrase_out stable, char_ready=0 throughout; next record's chars held off until the cycle after the handshake.
- resync: 'C','#','4' then 'D' with char_sof=1, followed by 0x00,'2','0','5','1' → single phrase note 26, vol 5, inst 1 = 0x1A15, phrase_err=0.
- reset: reset_n=0 for 1 cycle after 3 accepted chars → all outputs 0; the next full record 'G',0x00,'1','1','2','0' decodes to 0x1330.
